// File: rtl/slot_pkg.sv
// Shared slot definitions for the slot encoder and the 4-to-9 slot decoder.
package slot_pkg;

  localparam int NSLOTS_DEF = 9;
  localparam int IDXW_DEF   = 4;

  typedef logic [IDXW_DEF-1:0]   slot_idx_t;
  typedef logic [NSLOTS_DEF-1:0] slot_vec_t;

  // All-ones index marks "no slot"; never a legal slot because NSLOTS <= 2**IDXW - 1.
  localparam slot_idx_t SLOT_NONE = {IDXW_DEF{1'b1}};

endpackage

// File: rtl/slot_rr_pick.sv
// Combinational slot picker: classifies a slot vector and chooses one set bit,
// either round-robin after last_slot or lowest index first.
module slot_rr_pick
  import slot_pkg::*;
#(
  parameter int NSLOTS = NSLOTS_DEF,
  parameter int IDXW   = IDXW_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic [NSLOTS-1:0] slot_vec,
  input  logic [IDXW-1:0]   last_slot,
  output logic [IDXW-1:0]   pick_idx,
  output logic              is_zero,
  output logic              is_multi
);

  logic [IDXW-1:0] low_idx;
  logic [IDXW-1:0] above_idx;
  logic            above_found;

  assign is_zero  = (slot_vec == '0);
  assign is_multi = |(slot_vec & (slot_vec - NSLOTS'(1)));

  always_comb begin
    low_idx = '0;
    for (int j = NSLOTS - 1; j >= 0; j--) begin
      if (slot_vec[j]) begin
        low_idx = IDXW'(j);
      end
    end
  end

  // Lowest set bit strictly above last_slot; if none exists the search wraps,
  // which is the same as taking the overall lowest set bit.
  always_comb begin
    above_idx   = '0;
    above_found = 1'b0;
    for (int j = NSLOTS - 1; j >= 0; j--) begin
      if (slot_vec[j] && (IDXW'(j) > last_slot)) begin
        above_idx   = IDXW'(j);
        above_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_idx = low_idx;
    if (RR_EN && above_found) begin
      pick_idx = above_idx;
    end
  end

endmodule

// File: rtl/slot_encoder.sv
// Registered one-hot-to-index slot encoder with a single valid/ready output stage,
// zero-hot / multi-hot detection and a saturating error counter.
module slot_encoder
  import slot_pkg::*;
#(
  parameter int NSLOTS = NSLOTS_DEF,
  parameter int IDXW   = IDXW_DEF,
  parameter bit RR_EN  = 1'b1,
  parameter int ERRW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSLOTS-1:0] one_hot_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   current_slot,
  output logic              err_zero,
  output logic              err_multi,
  output logic [ERRW-1:0]   err_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state;
  logic            accept;
  logic [IDXW-1:0] last_slot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_zero;
  logic            pick_multi;

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  slot_rr_pick #(
    .NSLOTS (NSLOTS),
    .IDXW   (IDXW),
    .RR_EN  (RR_EN)
  ) u_pick (
    .slot_vec  (one_hot_in),
    .last_slot (last_slot),
    .pick_idx  (pick_idx),
    .is_zero   (pick_zero),
    .is_multi  (pick_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL:  if (out_ready && !accept) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // Output register only loads on accept, so it holds stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_slot <= '0;
      err_zero     <= 1'b0;
      err_multi    <= 1'b0;
      last_slot    <= IDXW'(NSLOTS - 1);
    end else if (accept) begin
      current_slot <= pick_zero ? {IDXW{1'b1}} : pick_idx;
      err_zero     <= pick_zero;
      err_multi    <= pick_multi;
      if (!pick_zero) begin
        last_slot <= pick_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && (pick_zero || pick_multi) && (err_count != {ERRW{1'b1}})) begin
      err_count <= err_count + ERRW'(1);
    end
  end

endmodule
